// File: rtl/wvfm_loader.sv
// Framed byte-stream loader for the waveform LUT: length header, payload, checksum.
// Payload bytes are written to consecutive LUT addresses from 0; busy guards the shared address path.
module wvfm_loader #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [7:0]        lut_din,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_FIN
    } state_t;

    localparam logic [1:0]     ERR_NONE  = 2'd0;
    localparam logic [1:0]     ERR_LEN   = 2'd1;
    localparam logic [1:0]     ERR_CSUM  = 2'd2;
    localparam logic [1:0]     ERR_ABORT = 2'd3;
    localparam logic [LEN_W:0] MAX_LEN   = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_t            state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              lut_we_q, lut_we_d;
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic [7:0]        lut_din_q, lut_din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        acc_q, acc_d;

    logic              fire;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   wr_inc;
    logic [7:0]        csum_sum;
    logic              receiving;

    always_comb begin
        fire      = s_valid && s_ready_q;
        len_full  = LEN_W'({s_data, len_lo_q});
        wr_inc    = wr_count_q + (ADDR_W+1)'(1);
        csum_sum  = acc_q + s_data;
        receiving = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);

        state_d    = state_q;
        lut_we_d   = 1'b0;
        lut_addr_d = lut_addr_q;
        lut_din_d  = lut_din_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        acc_d      = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = ERR_NONE;
                    wr_count_d = '0;
                    acc_d      = '0;
                end
            end
            S_LEN0: begin
                if (fire) begin
                    len_lo_d = s_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (fire) begin
                    if (len_full == '0 || {1'b0, len_full} > MAX_LEN) begin
                        state_d = S_IDLE;
                        err_d   = ERR_LEN;
                        busy_d  = 1'b0;
                    end else begin
                        len_d   = len_full[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    lut_we_d   = 1'b1;
                    lut_addr_d = wr_count_q[ADDR_W-1:0];
                    lut_din_d  = s_data;
                    wr_count_d = wr_inc;
                    acc_d      = acc_q + s_data;
                    if (wr_inc == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (fire) begin
                    state_d = S_FIN;
                    if (csum_sum == 8'h00) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = ERR_CSUM;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort discards whatever the current cycle accepted, including a data byte.
        if (abort && receiving) begin
            state_d    = S_IDLE;
            err_d      = ERR_ABORT;
            busy_d     = 1'b0;
            done_d     = done_q;
            lut_we_d   = 1'b0;
            lut_addr_d = lut_addr_q;
            lut_din_d  = lut_din_q;
            wr_count_d = wr_count_q;
            acc_d      = acc_q;
        end

        s_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                    (state_d == S_DATA) || (state_d == S_CSUM);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            s_ready_q  <= 1'b0;
            lut_we_q   <= 1'b0;
            lut_addr_q <= '0;
            lut_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            wr_count_q <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            lut_we_q   <= lut_we_d;
            lut_addr_q <= lut_addr_d;
            lut_din_q  <= lut_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign lut_we   = lut_we_q;
    assign lut_addr = lut_addr_q;
    assign lut_din  = lut_din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wvfm_loader.sv
// Directed bench for wvfm_loader: nominal, full-table, bad length, checksum, abort/reset, backpressure.
module tb_wvfm_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        lut_we;
    logic [11:0] lut_addr;
    logic [7:0]  lut_din;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [12:0] wr_count;

    wvfm_loader #(.ADDR_W(12), .LEN_W(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_din(lut_din),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (lut_we === 1'b1) wq.push_back('{int'(lut_addr), int'(lut_din), cyc});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        s_data  = b;
        s_valid = 1'b1;
        w = 0;
        while (s_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (s_ready !== 1'b1) chk("ready_timeout", int'(s_ready), 1);
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        int bad;
        int zero;

        // Reset state
        #1 rstn = 1'b0;
        #1;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_lut_we", int'(lut_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_wr_count", int'(wr_count), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // 1: nominal load
        base = wq.size();
        do_start();
        chk("t1_busy_rise", int'(busy), 1);
        chk("t1_ready_len0", int'(s_ready), 1);
        send(8'h04); send(8'h00);
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02);
        send(8'hFE);
        s_valid = 1'b0;
        chk("t1_done", int'(done), 1);
        chk("t1_err", int'(err), 0);
        chk("t1_wr_count", int'(wr_count), 4);
        chk("t1_fin_ready", int'(s_ready), 0);
        chk("t1_fin_busy", int'(busy), 1);
        tick();
        chk("t1_busy_fall", int'(busy), 0);
        chk("t1_nwrites", wq.size() - base, 4);
        if (wq.size() - base == 4) begin
            chk("t1_w0", (wq[base].a << 8) | wq[base].d, 12'h000 << 8 | 8'hAA);
            chk("t1_w1", (wq[base+1].a << 8) | wq[base+1].d, 12'h001 << 8 | 8'h55);
            chk("t1_w2", (wq[base+2].a << 8) | wq[base+2].d, 12'h002 << 8 | 8'h01);
            chk("t1_w3", (wq[base+3].a << 8) | wq[base+3].d, 12'h003 << 8 | 8'h02);
            chk("t1_consecutive", wq[base+3].cyc - wq[base].cyc, 3);
        end
        $display("txn t1 nominal: writes=%0d done=%0b err=%0d", wq.size() - base, done, err);

        // 2: full table with random gaps
        tick();
        base = wq.size();
        do_start();
        send(8'h00); send(8'h10);
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            send(8'(i));
        end
        send(8'h00);
        s_valid = 1'b0;
        tick();
        n = wq.size() - base;
        chk("t2_nwrites", n, 4096);
        bad = 0;
        zero = 0;
        for (int k = 0; k < n && k < 4096; k++) begin
            if (wq[base+k].a != k || wq[base+k].d != (k & 255)) bad++;
            if (wq[base+k].a == 0) zero++;
        end
        chk("t2_bad_entries", bad, 0);
        chk("t2_addr0_writes", zero, 1);
        if (n > 0) chk("t2_last_addr", wq[wq.size()-1].a, 12'hFFF);
        chk("t2_wr_count", int'(wr_count), 13'h1000);
        chk("t2_done", int'(done), 1);
        chk("t2_err", int'(err), 0);
        $display("txn t2 full table: writes=%0d wr_count=0x%0h done=%0b", n, wr_count, done);

        // 3: bad lengths
        tick();
        base = wq.size();
        do_start();
        send(8'h00); send(8'h00);
        s_valid = 1'b0;
        chk("t3a_err", int'(err), 1);
        chk("t3a_busy", int'(busy), 0);
        chk("t3a_ready", int'(s_ready), 0);
        tick();
        do_start();
        chk("t3b_err_cleared", int'(err), 0);
        send(8'h01); send(8'h10);
        s_valid = 1'b0;
        chk("t3b_err", int'(err), 1);
        chk("t3b_busy", int'(busy), 0);
        tick(); tick();
        chk("t3_nwrites", wq.size() - base, 0);
        chk("t3_done", int'(done), 0);
        $display("txn t3 bad length: err=%0d writes=%0d", err, wq.size() - base);

        // 4: checksum mismatch
        base = wq.size();
        do_start();
        send(8'h02); send(8'h00);
        send(8'h10); send(8'h20);
        send(8'h00);
        s_valid = 1'b0;
        tick();
        chk("t4_err", int'(err), 2);
        chk("t4_done", int'(done), 0);
        chk("t4_nwrites", wq.size() - base, 2);
        if (wq.size() - base == 2) chk("t4_w1", (wq[base+1].a << 8) | wq[base+1].d, 12'h001 << 8 | 8'h20);
        $display("txn t4 csum mismatch: err=%0d writes=%0d", err, wq.size() - base);

        // 5a: abort on the 3rd data acceptance
        tick();
        base = wq.size();
        do_start();
        send(8'h08); send(8'h00);
        send(8'hA1); send(8'hA2);
        s_data = 8'hA3;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        chk("t5a_ready", int'(s_ready), 0);
        chk("t5a_err", int'(err), 3);
        chk("t5a_busy", int'(busy), 0);
        chk("t5a_wr_count", int'(wr_count), 2);
        repeat (3) tick();
        chk("t5a_nwrites", wq.size() - base, 2);
        if (wq.size() - base == 2) chk("t5a_w1", (wq[base+1].a << 8) | wq[base+1].d, 12'h001 << 8 | 8'hA2);
        $display("txn t5a abort: err=%0d writes=%0d", err, wq.size() - base);

        // 5b: asynchronous reset mid-DATA
        do_start();
        send(8'h08); send(8'h00);
        send(8'hB1); send(8'hB2);
        chk("t5b_we_before", int'(lut_we), 1);
        rstn = 1'b0;
        #1;
        chk("t5b_lut_we", int'(lut_we), 0);
        chk("t5b_lut_addr", int'(lut_addr), 0);
        chk("t5b_lut_din", int'(lut_din), 0);
        chk("t5b_busy", int'(busy), 0);
        chk("t5b_ready", int'(s_ready), 0);
        chk("t5b_wr_count", int'(wr_count), 0);
        chk("t5b_err", int'(err), 0);
        s_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        $display("txn t5b reset: busy=%0b lut_we=%0b wr_count=%0d", busy, lut_we, wr_count);

        // 6: start while busy, FIN backpressure
        base = wq.size();
        do_start();
        send(8'h03); send(8'h00);
        send(8'h11);
        s_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy_kept", int'(busy), 1);
        chk("t6_wr_count_kept", int'(wr_count), 1);
        send(8'h22); send(8'h33);
        send(8'h9A);
        s_data = 8'h01;
        chk("t6_fin_ready", int'(s_ready), 0);
        tick();
        chk("t6_done", int'(done), 1);
        chk("t6_busy_fall", int'(busy), 0);
        chk("t6_wr_count", int'(wr_count), 3);
        chk("t6_nwrites", wq.size() - base, 3);
        base = wq.size();
        do_start();
        send(8'h01);
        send(8'h00);
        send(8'h77);
        send(8'h89);
        s_valid = 1'b0;
        tick();
        chk("t6_held_done", int'(done), 1);
        chk("t6_held_err", int'(err), 0);
        chk("t6_held_wr_count", int'(wr_count), 1);
        if (wq.size() - base == 1) chk("t6_held_w0", (wq[base].a << 8) | wq[base].d, 12'h000 << 8 | 8'h77);
        else chk("t6_held_nwrites", wq.size() - base, 1);
        $display("txn t6 backpressure: done=%0b err=%0d wr_count=%0d", done, err, wr_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
